// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin owner arbiter driving the select of a downstream 4:1 data mux.
// Optional ARB_PRIO0_EN: source 0 wins every arbitration point it requests at.
module rr_mux_sel_arbiter #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic             rdy,
  output logic [1:0]       sel,
  output logic [3:0]       gnt,
  output logic             vld,
  output logic [CNT_W-1:0] beat
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [1:0]       ptr_q, ptr_d;

  logic       accept;
  logic       last_beat;
  logic       release_own;
  logic [1:0] winner;

  // First set bit of mask, searching upward from p+1 with wrap-around.
  function automatic logic [1:0] arb(input logic [3:0] mask, input logic [1:0] p);
    logic [1:0] res;
    logic [1:0] idx;
    logic       found;
    res   = p;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = p + 2'(i);
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] res;
`ifdef ARB_PRIO0_EN
    if (r[0]) begin
      res = 2'd0;
    end else begin
      res = arb(r & 4'b1110, p);
    end
`else
    res = arb(r, p);
`endif
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= 2'b00;
      gnt_q   <= 4'b0000;
      beat_q  <= '0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      beat_q  <= beat_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    accept      = vld && rdy;
    last_beat   = (beat_q == CNT_W'(BURST_LEN - 1));
    release_own = !req[sel_q] || (accept && last_beat);
    winner      = pick(req, ptr_q);

    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    beat_d  = beat_q;
    ptr_d   = ptr_q;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StBusy;
          sel_d   = winner;
          gnt_d   = 4'b0001 << winner;
          beat_d  = '0;
          ptr_d   = winner;
        end
      end
      StBusy: begin
        if (release_own) begin
          // Re-arbitrate on the release edge so ownership hands over without a bubble.
          if (|req) begin
            sel_d  = winner;
            gnt_d  = 4'b0001 << winner;
            beat_d = '0;
            ptr_d  = winner;
          end else begin
            state_d = StIdle;
            gnt_d   = 4'b0000;
            beat_d  = '0;
          end
        end else if (accept) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    vld = (state_q == StBusy) && req[sel_q];
  end

  assign sel  = sel_q;
  assign gnt  = gnt_q;
  assign beat = beat_q;

endmodule

// File: doc/rr_mux_sel_arbiter.md
Name: rr_mux_sel_arbiter

Overview:
- Round-robin arbiter that drives the 2-bit select of the downstream 4:1 data mux.
- Four sources raise requests. The block grants one source at a time, holds the select stable for a burst of up to BURST_LEN accepted beats, then moves to the next requester.
- Sits directly upstream of the 4:1 mux: its sel output feeds the mux select, and vld/rdy frame the muxed data toward the consumer.

Parameters:
- BURST_LEN, 4, maximum accepted beats per grant; legal range 1..15.
- CNT_W, 4, beat counter width; must satisfy 2^CNT_W > BURST_LEN.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  4  per-source request; bit i = source i has data
- rdy  input  1  downstream accepts current beat
- sel  output 2  select to 4:1 mux; index of current owner
- gnt  output 4  one-hot owner indication; all-zero when idle
- vld  output 1  muxed data valid toward consumer
- beat output CNT_W  beats accepted in current burst

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset values: state=IDLE, sel=2'b00, gnt=4'b0000, beat=0, internal last-owner ptr=3, so source 0 wins first.
- Combinational outputs:
  - vld = (state==BUSY) && req[sel].
  - A beat is accepted when vld && rdy.
- Registered outputs: sel, gnt, beat and state are registered. sel holds its last value in IDLE; gnt is 0 in IDLE.
- Arbitration function ARB(mask): first set bit of mask searched from (ptr+1) mod 4 upward with wrap-around.
- IDLE state:
  - req==0: stay IDLE.
  - Otherwise, on the next edge: BUSY, sel=ARB(req), gnt=onehot(sel), beat=0, ptr=sel.
  - Latency from req rising to gnt/sel valid is 1 cycle.
- BUSY state:
  - Accepted beat, not last: beat increments.
  - rdy low: beat and sel hold (stall, no timeout).
  - Release when an accepted beat has beat==BURST_LEN-1, or when req[sel]==0 at the edge (owner withdrew; no beat that cycle).
- On release:
  - Re-arbitrate the same edge: if req has any bit set, new owner = ARB(req) searching from sel+1, beat=0, ptr updated, state stays BUSY (no bubble cycle).
  - The current owner may re-win only if it is the sole requester.
  - If req==0, go to IDLE and gnt=0.
- BURST_LEN=1: release after every accepted beat.
- Request changes of non-owners mid-burst: ignored until the next release.
- rst asserted mid-burst: immediate clear to reset values. The partial burst is dropped and no vld is asserted while rst is high.

Optional Feature:
- Macro: ARB_PRIO0_EN.
- Defined: at every arbitration point, if req[0]=1 then source 0 wins regardless of ptr. Otherwise round-robin among sources 1..3, using ptr as normal. Bursts are never preempted; priority applies only at release/IDLE arbitration.
- Undefined: pure 4-way round-robin as above.

Test Plan:
- Reset then req=4'b1111, rdy=1, BURST_LEN=4 -> 1 cycle later gnt=0001, sel=0. vld high 4 cycles, beat 0..3. Then sel=1, 2, 3, 0 in order, each for 4 beats, with no idle cycle between owners.
- req=4'b0100, rdy toggling 1,0,1,0 -> sel=2 held. beat advances only on rdy=1 cycles, release after 4 accepted beats. Owner re-granted (sole requester) with beat=0.
- Owner 1 drops req after 2 beats while req[3]=1 -> vld=0 that cycle. Next edge sel=3, gnt=1000, beat=0.
- Single requester drops req after 1 beat, req becomes 0000 -> next edge gnt=0000, state IDLE, sel stays 1.
- rst pulsed while BUSY with beat=2 -> sel=0, gnt=0, beat=0, vld=0 asynchronously. After release with req=1111, source 0 is granted first.
- ARB_PRIO0_EN defined, req=4'b1011 held -> grant sequence 0,0,0...; with req[0] cleared -> 1,3,1,3.
